// File: rtl/sar_conv_ctrl.sv
// SAR conversion sequencer: pulses cnvst, captures sar on each eoc rise, averages 2**AVG_LOG2 samples.
// Latency: data_valid rises the cycle after the final eoc edge of a block is sampled.
// Backpressure: none; start is ignored while busy, and an eoc that never arrives aborts to IDLE.
module sar_conv_ctrl #(
  parameter int DATA_W       = 8,
  parameter int CNVST_CYCLES = 2,
  parameter int TIMEOUT      = 32,
  parameter int GAP_CYCLES   = 4,
  parameter int AVG_LOG2     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont_en,
  input  logic              eoc,
  input  logic [DATA_W-1:0] sar,
  output logic              cnvst,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              timeout_err
);

  localparam int ACC_W     = DATA_W + AVG_LOG2;
  localparam int IDX_W     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int CNT_MAX_A = (CNVST_CYCLES > GAP_CYCLES) ? CNVST_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX   = (TIMEOUT > CNT_MAX_A) ? TIMEOUT : CNT_MAX_A;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               eoc_d;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_sum;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic               blk_done;
  logic               eoc_rise;
  logic               start_end;
  logic               wait_end;
  logic               gap_end;
  logic               last_smp;
  logic               go;

  // A level already high when WAIT is entered has eoc_d==1, so it never looks like an edge.
  assign eoc_rise  = eoc & ~eoc_d;
  assign start_end = (cnt == CNT_W'(CNVST_CYCLES - 1));
  assign wait_end  = (cnt == CNT_W'(TIMEOUT - 1));
  assign gap_end   = (cnt == CNT_W'(GAP_CYCLES - 1));
  assign acc_sum   = acc + ACC_W'(sar);
  assign last_smp  = (idx == IDX_LAST);
  assign go        = start | cont_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (go) state_nxt = S_START;
      end
      S_START: begin
        if (start_end) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (eoc_rise) begin
          state_nxt = S_GAP;
        end else if (wait_end) begin
          state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_end) begin
          state_nxt = (!blk_done || cont_en) ? S_START : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cnvst = 1'b0;
    busy  = 1'b0;
    case (state)
      S_IDLE:  busy = 1'b0;
      S_START: begin
        cnvst = 1'b1;
        busy  = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

  // One shared timer; restarts from zero on every state change and idles at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if ((state_nxt != state) || (state == S_IDLE)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      eoc_d       <= 1'b0;
      acc         <= '0;
      idx         <= '0;
      blk_done    <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      eoc_d      <= eoc;
      data_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            acc         <= '0;
            idx         <= '0;
            blk_done    <= 1'b0;
            timeout_err <= 1'b0;
          end
        end
        S_WAIT: begin
          if (eoc_rise) begin
            acc <= acc_sum;
            if (last_smp) begin
              data_out   <= DATA_W'(acc_sum >> AVG_LOG2);
              data_valid <= 1'b1;
              blk_done   <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else if (wait_end) begin
            timeout_err <= 1'b1;
            acc         <= '0;
            idx         <= '0;
          end
        end
        S_GAP: begin
          // Completed block: start the next one (if any) from a clean accumulator.
          if (gap_end && blk_done) begin
            acc      <= '0;
            idx      <= '0;
            blk_done <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_conv_ctrl.sv
// Directed bench for sar_conv_ctrl: one instance without averaging, one averaging 4 samples,
// each driven by a small behavioural sar_logic model.
module tb_sar_conv_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_v [2];
  logic       cont_v  [2];
  logic       eoc_v   [2];
  logic [7:0] sar_v   [2];
  logic       cnvst_w [2];
  logic       busy_w  [2];
  logic       dv_w    [2];
  logic       terr_w  [2];
  logic [7:0] dout_w  [2];

  sar_conv_ctrl #(.AVG_LOG2(0)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .cont_en(cont_v[0]), .eoc(eoc_v[0]),
    .sar(sar_v[0]), .cnvst(cnvst_w[0]), .busy(busy_w[0]), .data_out(dout_w[0]),
    .data_valid(dv_w[0]), .timeout_err(terr_w[0])
  );

  sar_conv_ctrl #(.AVG_LOG2(2)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[1]), .cont_en(cont_v[1]), .eoc(eoc_v[1]),
    .sar(sar_v[1]), .cnvst(cnvst_w[1]), .busy(busy_w[1]), .data_out(dout_w[1]),
    .data_valid(dv_w[1]), .timeout_err(terr_w[1])
  );

  typedef struct {
    logic [7:0] s [4];
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [6];

  // sar_logic model state
  int         cd [2];
  int         hold [2];
  int         k [2];
  int         eoc_dly;
  logic       model_on [2];
  logic [7:0] samp [2][8];

  // observed statistics
  int   pulses [2], hi_run [2], lo_run [2], hmin [2], hmax [2], gmin [2], gmax [2];
  int   dv_cnt [2], dv_cyc [2], dv_prev [2], fall_cyc [2], terr_cyc [2], eoc_cyc [2];
  logic seen_fall [2], prev_c [2], prev_t [2];
  int   cyc;
  int   n_chk, n_fail;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_stats(input int d);
    pulses[d] = 0; hi_run[d] = 0; lo_run[d] = 0;
    hmin[d] = 999; hmax[d] = 0; gmin[d] = 999; gmax[d] = 0;
    dv_cnt[d] = 0; dv_cyc[d] = -1; dv_prev[d] = -1;
    fall_cyc[d] = -1; terr_cyc[d] = -1; eoc_cyc[d] = -1; seen_fall[d] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (cd[d] > 0) begin
        cd[d]--;
        if (cd[d] == 0) begin
          eoc_v[d]   = 1'b1;
          sar_v[d]   = samp[d][k[d] % 8];
          k[d]++;
          hold[d]    = 2;
          eoc_cyc[d] = cyc;
        end
      end else if (hold[d] > 0) begin
        hold[d]--;
        if (hold[d] == 0) eoc_v[d] = 1'b0;
      end
      if (model_on[d] && prev_c[d] && !cnvst_w[d]) cd[d] = eoc_dly;

      if (cnvst_w[d] && !prev_c[d]) begin
        pulses[d]++;
        if (seen_fall[d]) begin
          if (lo_run[d] < gmin[d]) gmin[d] = lo_run[d];
          if (lo_run[d] > gmax[d]) gmax[d] = lo_run[d];
        end
        hi_run[d] = 1;
      end else if (cnvst_w[d]) begin
        hi_run[d]++;
      end
      if (!cnvst_w[d] && prev_c[d]) begin
        fall_cyc[d]  = cyc;
        seen_fall[d] = 1'b1;
        lo_run[d]    = 1;
        if (hi_run[d] < hmin[d]) hmin[d] = hi_run[d];
        if (hi_run[d] > hmax[d]) hmax[d] = hi_run[d];
      end else if (!cnvst_w[d]) begin
        lo_run[d]++;
      end
      if (dv_w[d]) begin
        dv_cnt[d]++;
        dv_prev[d] = dv_cyc[d];
        dv_cyc[d]  = cyc;
      end
      if (terr_w[d] && !prev_t[d]) terr_cyc[d] = cyc;
      prev_c[d] = cnvst_w[d];
      prev_t[d] = terr_w[d];
    end
  endtask

  function automatic int getv(input int d, input int sel);
    case (sel)
      0:       return dv_cnt[d];
      1:       return pulses[d];
      2:       return (fall_cyc[d] >= 0) ? 1 : 0;
      default: return (terr_cyc[d] >= 0) ? 1 : 0;
    endcase
  endfunction

  task automatic wait_for(input string nm, input int d, input int sel, input int target,
                          input int budget);
    int b;
    b = 0;
    while (getv(d, sel) < target && b < budget) begin
      step();
      b++;
    end
    chk({nm, " reached in time"}, (getv(d, sel) >= target) ? 1 : 0, 1);
  endtask

  task automatic pulse_start(input int d);
    start_v[d] = 1'b1;
    step();
    start_v[d] = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    tbl[0].s = '{8'd10,  8'd11,  8'd12,  8'd13};  tbl[0].exp = 8'd11;
    tbl[1].s = '{8'd255, 8'd255, 8'd255, 8'd255}; tbl[1].exp = 8'd255;
    tbl[2].s = '{8'd0,   8'd0,   8'd0,   8'd3};   tbl[2].exp = 8'd0;
    tbl[3].s = '{8'd1,   8'd2,   8'd3,   8'd5};   tbl[3].exp = 8'd2;
    tbl[4].s = '{8'd200, 8'd100, 8'd50,  8'd25};  tbl[4].exp = 8'd93;
    tbl[5].s = '{8'd254, 8'd255, 8'd255, 8'd255}; tbl[5].exp = 8'd254;

    n_chk = 0; n_fail = 0; cyc = 0; eoc_dly = 10; rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0; cont_v[d] = 1'b0; eoc_v[d] = 1'b0; sar_v[d] = 8'h00;
      cd[d] = 0; hold[d] = 0; k[d] = 0; model_on[d] = 1'b0;
      prev_c[d] = 1'b0; prev_t[d] = 1'b0;
      for (int j = 0; j < 8; j++) samp[d][j] = 8'h00;
      clear_stats(d);
    end

    // reset state
    steps(3);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset[%0d] cnvst", d), int'(cnvst_w[d]), 0);
      chk($sformatf("reset[%0d] busy", d), int'(busy_w[d]), 0);
      chk($sformatf("reset[%0d] data_valid", d), int'(dv_w[d]), 0);
      chk($sformatf("reset[%0d] timeout_err", d), int'(terr_w[d]), 0);
      chk($sformatf("reset[%0d] data_out", d), int'(dout_w[d]), 0);
    end
    rst = 1'b1;
    steps(2);

    // T1: single conversion without averaging
    clear_stats(0);
    samp[0][0] = 8'hA5; k[0] = 0; model_on[0] = 1'b1;
    pulse_start(0);
    wait_for("t1 data_valid", 0, 0, 1, 100);
    steps(10);
    chk("t1 data_out", int'(dout_w[0]), 8'hA5);
    chk("t1 data_valid cycles", dv_cnt[0], 1);
    chk("t1 cnvst pulses", pulses[0], 1);
    chk("t1 cnvst high min", hmin[0], 2);
    chk("t1 cnvst high max", hmax[0], 2);
    chk("t1 eoc-to-valid latency", dv_cyc[0] - eoc_cyc[0], 1);
    chk("t1 busy after", int'(busy_w[0]), 0);

    // T2: averaging table on the 4-sample instance
    for (int i = 0; i < 6; i++) begin
      clear_stats(1);
      for (int j = 0; j < 4; j++) samp[1][j] = tbl[i].s[j];
      k[1] = 0; model_on[1] = 1'b1;
      pulse_start(1);
      wait_for($sformatf("t2[%0d] data_valid", i), 1, 0, 1, 300);
      steps(10);
      chk($sformatf("t2[%0d] data_out", i), int'(dout_w[1]), int'(tbl[i].exp));
      chk($sformatf("t2[%0d] data_valid cycles", i), dv_cnt[1], 1);
      chk($sformatf("t2[%0d] cnvst pulses", i), pulses[1], 4);
      chk($sformatf("t2[%0d] cnvst high", i), hmin[1] * 100 + hmax[1], 202);
      chk($sformatf("t2[%0d] low gap", i), gmin[1] * 100 + gmax[1], 1515);
      chk($sformatf("t2[%0d] busy after", i), int'(busy_w[1]), 0);
    end

    // T3: eoc never arrives
    clear_stats(1);
    model_on[1] = 1'b0;
    pulse_start(1);
    wait_for("t3 wait entry", 1, 2, 1, 20);
    wait_for("t3 timeout_err", 1, 3, 1, 60);
    chk("t3 timeout delay", terr_cyc[1] - fall_cyc[1], 32);
    chk("t3 busy at timeout", int'(busy_w[1]), 0);
    chk("t3 data_valid cycles", dv_cnt[1], 0);
    chk("t3 cnvst pulses", pulses[1], 1);
    steps(5);
    chk("t3 timeout_err sticky", int'(terr_w[1]), 1);
    for (int j = 0; j < 4; j++) samp[1][j] = 8'd8;
    k[1] = 0; model_on[1] = 1'b1;
    pulse_start(1);
    chk("t3 timeout_err cleared by start", int'(terr_w[1]), 0);
    chk("t3 busy after restart", int'(busy_w[1]), 1);
    wait_for("t3 recovery data_valid", 1, 0, 1, 300);
    chk("t3 recovery data_out", int'(dout_w[1]), 8);
    steps(10);

    // T4: continuous mode, then cont_en dropped mid-block
    clear_stats(1);
    for (int j = 0; j < 8; j++) samp[1][j] = 8'h3C;
    k[1] = 0;
    cont_v[1] = 1'b1;
    wait_for("t4 second result", 1, 0, 2, 400);
    chk("t4 data_out block 2", int'(dout_w[1]), 8'h3C);
    chk("t4 result period", dv_cyc[1] - dv_prev[1], 68);
    chk("t4 pulses at block 2", pulses[1], 8);
    wait_for("t4 mid block 3", 1, 1, 10, 100);
    cont_v[1] = 1'b0;
    wait_for("t4 third result", 1, 0, 3, 200);
    steps(40);
    chk("t4 data_valid cycles", dv_cnt[1], 3);
    chk("t4 data_out block 3", int'(dout_w[1]), 8'h3C);
    chk("t4 busy after drop", int'(busy_w[1]), 0);
    chk("t4 total pulses", pulses[1], 12);
    chk("t4 low gap", gmin[1] * 100 + gmax[1], 1515);

    // T5: one-cycle reset in WAIT
    clear_stats(1);
    for (int j = 0; j < 8; j++) samp[1][j] = 8'h77;
    k[1] = 0;
    pulse_start(1);
    wait_for("t5 wait entry", 1, 2, 1, 20);
    steps(3);
    rst = 1'b0;
    step();
    chk("t5 cnvst", int'(cnvst_w[1]), 0);
    chk("t5 busy", int'(busy_w[1]), 0);
    chk("t5 data_valid", int'(dv_w[1]), 0);
    chk("t5 timeout_err", int'(terr_w[1]), 0);
    chk("t5 data_out", int'(dout_w[1]), 0);
    chk("t5 data_out no-avg instance", int'(dout_w[0]), 0);
    rst = 1'b1;
    steps(40);
    chk("t5 data_valid after late eoc", dv_cnt[1], 0);
    chk("t5 busy after late eoc", int'(busy_w[1]), 0);

    // T6: eoc already high on WAIT entry, start while busy
    clear_stats(1);
    model_on[1] = 1'b0;
    eoc_v[1] = 1'b1;
    sar_v[1] = 8'hFF;
    pulse_start(1);
    wait_for("t6 wait entry", 1, 2, 1, 20);
    step();
    start_v[1] = 1'b1;
    step();
    start_v[1] = 1'b0;
    steps(2);
    eoc_v[1] = 1'b0;
    steps(3);
    sar_v[1] = 8'h40;
    eoc_v[1] = 1'b1;
    steps(2);
    eoc_v[1] = 1'b0;
    for (int j = 0; j < 3; j++) samp[1][j] = 8'h20;
    k[1] = 0; model_on[1] = 1'b1;
    wait_for("t6 data_valid", 1, 0, 1, 300);
    steps(40);
    chk("t6 data_out", int'(dout_w[1]), 8'h28);
    chk("t6 data_valid cycles", dv_cnt[1], 1);
    chk("t6 cnvst pulses", pulses[1], 4);
    chk("t6 busy after", int'(busy_w[1]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
